ps2_key_event: RTL and testbench

- Downstream consumer of the PS/2 scan-code receiver FIFO (data/ready/nextdata_n interface).
- Decodes Set-2 make/break/extended sequences into a held-key state, press counter, modifier flags and a one-cycle make event.
- Outputs feed the scan-code/ASCII seven-segment display path and any key-driven logic.
- Replaces the simple "pop whenever ready" logic with a protocol-aware stage.

---
 rtl/ps2_key_event_if.sv | 21 ++
 rtl/ps2_key_event.sv | 164 ++++++++++++++++
 tb/tb_ps2_key_event.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_if.sv
// rtl/ps2_key_event_if.sv - PS/2 receiver FIFO handshake bundle (data/ready/pop strobe/overflow)
interface ps2_key_event_if;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       ps2_overflow;
    logic       nextdata_n;

    modport master (
        output ps2_ready,
        output ps2_data,
        output ps2_overflow,
        input  nextdata_n
    );

    modport slave (
        input  ps2_ready,
        input  ps2_data,
        input  ps2_overflow,
        output nextdata_n
    );
endinterface

// File: rtl/ps2_key_event.sv
// rtl/ps2_key_event.sv - Set-2 make/break/E0 decoder producing held-key state, press count and shift flags
module ps2_key_event #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    ps2_key_event_if.slave       ps2,
    output logic                 key_valid,
    output logic [7:0]           key_code,
    output logic                 key_ext,
    output logic [CNT_WIDTH-1:0] press_cnt,
    output logic                 make_pulse,
    output logic                 shift_held,
    output logic                 overflow_seen
);

    localparam logic [7:0] CODE_EXT     = 8'hE0;
    localparam logic [7:0] CODE_BRK     = 8'hF0;
    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_e;

    state_e               state_q, state_d;
    logic                 nextdata_n_q, nextdata_n_d;
    logic                 key_valid_q, key_valid_d;
    logic [7:0]           key_code_q, key_code_d;
    logic                 key_ext_q, key_ext_d;
    logic [CNT_WIDTH-1:0] press_cnt_q, press_cnt_d;
    logic                 make_pulse_q, make_pulse_d;
    logic                 shift_l_q, shift_l_d;
    logic                 shift_r_q, shift_r_d;
    logic                 shift_held_q, shift_held_d;
    logic                 overflow_seen_q, overflow_seen_d;

    logic       accept;
    logic       do_make;
    logic       do_brk;
    logic       ext;
    logic [7:0] code;
    logic       is_prefix;
    logic       same_key;

    always_comb begin
        state_d         = state_q;
        key_valid_d     = key_valid_q;
        key_code_d      = key_code_q;
        key_ext_d       = key_ext_q;
        press_cnt_d     = press_cnt_q;
        shift_l_d       = shift_l_q;
        shift_r_d       = shift_r_q;
        make_pulse_d    = 1'b0;
        do_make         = 1'b0;
        do_brk          = 1'b0;
        ext             = 1'b0;
        code            = ps2.ps2_data;
        is_prefix       = (code == CODE_EXT) || (code == CODE_BRK);

        // Holding the strobe low for the cycle after a pop blocks a second accept of the same head byte.
        accept          = ps2.ps2_ready && nextdata_n_q;
        nextdata_n_d    = !accept;
        overflow_seen_d = overflow_seen_q || ps2.ps2_overflow;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == CODE_EXT)      state_d = ST_EXT;
                    else if (code == CODE_BRK) state_d = ST_BRK;
                    else                       do_make = 1'b1;
                end
                ST_EXT: begin
                    if (code == CODE_BRK)      state_d = ST_EXT_BRK;
                    else if (code == CODE_EXT) state_d = ST_EXT;
                    else begin
                        do_make = 1'b1;
                        ext     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    do_brk  = !is_prefix;
                end
                default: begin
                    state_d = ST_IDLE;
                    do_brk  = !is_prefix;
                    ext     = 1'b1;
                end
            endcase
        end

        same_key = key_valid_q && (code == key_code_q) && (ext == key_ext_q);

        if (do_make) begin
            if (!ext && code == CODE_SHIFT_L) begin
                shift_l_d = 1'b1;
            end else if (!ext && code == CODE_SHIFT_R) begin
                shift_r_d = 1'b1;
            end else if (!same_key) begin
                // Typematic repeats of the held key fall through without counting.
                key_code_d   = code;
                key_ext_d    = ext;
                key_valid_d  = 1'b1;
                press_cnt_d  = press_cnt_q + CNT_WIDTH'(1);
                make_pulse_d = 1'b1;
            end
        end

        if (do_brk) begin
            if (!ext && code == CODE_SHIFT_L) begin
                shift_l_d = 1'b0;
            end else if (!ext && code == CODE_SHIFT_R) begin
                shift_r_d = 1'b0;
            end else if (same_key) begin
                key_valid_d = 1'b0;
            end
        end

        shift_held_d = shift_l_d || shift_r_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            nextdata_n_q    <= 1'b1;
            key_valid_q     <= 1'b0;
            key_code_q      <= 8'h00;
            key_ext_q       <= 1'b0;
            press_cnt_q     <= '0;
            make_pulse_q    <= 1'b0;
            shift_l_q       <= 1'b0;
            shift_r_q       <= 1'b0;
            shift_held_q    <= 1'b0;
            overflow_seen_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            nextdata_n_q    <= nextdata_n_d;
            key_valid_q     <= key_valid_d;
            key_code_q      <= key_code_d;
            key_ext_q       <= key_ext_d;
            press_cnt_q     <= press_cnt_d;
            make_pulse_q    <= make_pulse_d;
            shift_l_q       <= shift_l_d;
            shift_r_q       <= shift_r_d;
            shift_held_q    <= shift_held_d;
            overflow_seen_q <= overflow_seen_d;
        end
    end

    assign ps2.nextdata_n = nextdata_n_q;
    assign key_valid      = key_valid_q;
    assign key_code       = key_code_q;
    assign key_ext        = key_ext_q;
    assign press_cnt      = press_cnt_q;
    assign make_pulse     = make_pulse_q;
    assign shift_held     = shift_held_q;
    assign overflow_seen  = overflow_seen_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// tb/tb_ps2_key_event.sv - directed bench for ps2_key_event with a queue-modelled receiver FIFO
module tb_ps2_key_event;

    logic       clk;
    logic       rstn;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] press_cnt;
    logic       make_pulse;
    logic       shift_held;
    logic       overflow_seen;

    ps2_key_event_if bus ();

    ps2_key_event #(.CNT_WIDTH(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ps2           (bus),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ext       (key_ext),
        .press_cnt     (press_cnt),
        .make_pulse    (make_pulse),
        .shift_held    (shift_held),
        .overflow_seen (overflow_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    int checks    = 0;
    int failures  = 0;
    int pulses    = 0;
    int low_cyc   = 0;
    int dbl_low   = 0;
    int pops      = 0;
    logic prev_low = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge: drive FIFO head, pop on acceptance at the posedge, sample at next negedge.
    task automatic cycle();
        logic acc;
        bus.ps2_ready = (fifo_q.size() != 0);
        bus.ps2_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        acc = rstn && bus.ps2_ready && (bus.nextdata_n === 1'b1);
        @(posedge clk);
        if (acc) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        @(negedge clk);
        if (make_pulse === 1'b1) pulses++;
        if (rstn && bus.nextdata_n === 1'b0) begin
            low_cyc++;
            if (prev_low) dbl_low++;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fifo_q.size() != 0 || bus.nextdata_n !== 1'b1) && n < 4000) begin
            cycle();
            n++;
        end
        chk({tag, "_drain_timeout"}, (n < 4000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;
    endtask

    initial begin
        rstn             = 1'b0;
        bus.ps2_ready    = 1'b0;
        bus.ps2_data     = 8'h00;
        bus.ps2_overflow = 1'b0;

        // Reset with a full FIFO: nothing may be consumed.
        fifo_q = '{8'h1C, 8'h1C, 8'hF0, 8'h1C};
        repeat (3) cycle();
        chk("rst_nextdata_n", bus.nextdata_n, 1);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_make_pulse", make_pulse, 0);
        chk("rst_shift_held", shift_held, 0);
        chk("rst_overflow_seen", overflow_seen, 0);
        chk("rst_no_consume", fifo_q.size(), 4);

        // 1C, typematic 1C, F0 1C
        pulses = 0; low_cyc = 0; dbl_low = 0;
        rstn = 1'b1;
        cycle();
        chk("t1_first_valid", key_valid, 1);
        chk("t1_first_code", key_code, 8'h1C);
        chk("t1_first_cnt", press_cnt, 1);
        chk("t1_first_pulse", make_pulse, 1);
        chk("t1_first_pop_low", bus.nextdata_n, 0);
        cycle();
        chk("t1_pulse_one_cycle", make_pulse, 0);
        drain("t1");
        chk("t1_valid", key_valid, 0);
        chk("t1_code", key_code, 8'h1C);
        chk("t1_cnt", press_cnt, 1);
        chk("t1_pulses", pulses, 1);
        chk("t1_low_cycles", low_cyc, 4);
        chk("t1_no_double_low", dbl_low, 0);

        // E0 75 then E0 F0 75
        pulses = 0;
        fifo_q = '{8'hE0, 8'h75};
        drain("t2a");
        chk("t2_make_valid", key_valid, 1);
        chk("t2_make_ext", key_ext, 1);
        chk("t2_make_code", key_code, 8'h75);
        chk("t2_make_cnt", press_cnt, 2);
        fifo_q = '{8'hE0, 8'hF0, 8'h75};
        drain("t2b");
        chk("t2_brk_valid", key_valid, 0);
        chk("t2_brk_ext", key_ext, 1);
        chk("t2_brk_code", key_code, 8'h75);
        chk("t2_pulses", pulses, 1);

        // Shift around a press/release of 1C
        do_reset();
        pulses = 0;
        fifo_q = '{8'h12};
        drain("t3a");
        chk("t3_shift_set", shift_held, 1);
        chk("t3_shift_no_cnt", press_cnt, 0);
        chk("t3_shift_no_valid", key_valid, 0);
        fifo_q = '{8'h1C, 8'hF0, 8'h1C};
        drain("t3b");
        chk("t3_shift_still", shift_held, 1);
        chk("t3_code", key_code, 8'h1C);
        chk("t3_cnt", press_cnt, 1);
        chk("t3_valid", key_valid, 0);
        fifo_q = '{8'hF0, 8'h12};
        drain("t3c");
        chk("t3_shift_clear", shift_held, 0);
        chk("t3_pulses", pulses, 1);

        // 256 alternating makes, counter wraps
        do_reset();
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            fifo_q.push_back(8'h16);
            fifo_q.push_back(8'h1E);
        end
        drain("t4");
        chk("t4_pulses", pulses, 256);
        chk("t4_cnt_wrap", press_cnt, 8'h00);
        chk("t4_code", key_code, 8'h1E);
        chk("t4_valid", key_valid, 1);

        // Double break prefix is an error; 2B is then a fresh make
        pulses = 0;
        fifo_q = '{8'hF0, 8'hF0, 8'h2B};
        drain("t5");
        chk("t5_code", key_code, 8'h2B);
        chk("t5_cnt", press_cnt, 1);
        chk("t5_valid", key_valid, 1);
        chk("t5_pulses", pulses, 1);

        // Sticky overflow
        bus.ps2_overflow = 1'b1;
        cycle();
        bus.ps2_overflow = 1'b0;
        chk("t6_ovf_set", overflow_seen, 1);
        repeat (3) cycle();
        chk("t6_ovf_sticky", overflow_seen, 1);
        rstn = 1'b0;
        cycle();
        chk("t6_ovf_cleared", overflow_seen, 0);
        rstn = 1'b1;

        // Reset after a lone E0 discards the prefix
        fifo_q = '{8'hE0};
        drain("t7a");
        do_reset();
        fifo_q = '{8'h75};
        drain("t7b");
        chk("t7_ext", key_ext, 0);
        chk("t7_code", key_code, 8'h75);
        chk("t7_cnt", press_cnt, 1);

        chk("all_pops_strobed", low_cyc, pops);
        chk("all_no_double_low", dbl_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
